// File: rtl/btn_pkg.sv
// Shared button definitions for the input controller, bottom-bar renderer and game core.
// The priority helper picks the highest-numbered active request.
package btn_pkg;

    localparam int NUM_BTN   = 4;
    localparam int BTN_IDX_W = 2;

    localparam logic [BTN_IDX_W-1:0] BTN_RIGHT = 2'd0;
    localparam logic [BTN_IDX_W-1:0] BTN_LEFT  = 2'd1;
    localparam logic [BTN_IDX_W-1:0] BTN_UP    = 2'd2;
    localparam logic [BTN_IDX_W-1:0] BTN_AUX   = 2'd3;

    // Ascending scan, so the highest set bit is the last one written.
    function automatic logic [BTN_IDX_W-1:0] btn_prio_code(input logic [NUM_BTN-1:0] req);
        logic [BTN_IDX_W-1:0] code;
        code = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (req[i]) begin
                code = BTN_IDX_W'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One key: two-flop synchroniser (inverted to active-high) followed by a
// stability counter that accepts a level only after DEBOUNCE_CYCLES steady cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= ~key_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/btn_input_ctrl.sv
// Debounces four keys, stretches their highlight over HOLD_FRAMES frames and
// queues one press event per button onto a fixed-priority valid/ack channel.
module btn_input_ctrl
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int HOLD_FRAMES     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   key_n,
    input  logic                 frame_tick,
    output logic [NUM_BTN-1:0]   btn_state,
    output logic                 evt_valid,
    output logic [BTN_IDX_W-1:0] evt_code,
    input  logic                 evt_ack
);

    localparam int                HOLD_W    = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

    logic [NUM_BTN-1:0]   w_stable;
    logic [NUM_BTN-1:0]   w_rise;
    logic [NUM_BTN-1:0]   w_clear;
    logic [NUM_BTN-1:0]   w_pend_next;
    logic [NUM_BTN-1:0]   r_stable_d;
    logic [NUM_BTN-1:0]   r_pend;
    logic                 r_valid;
    logic [BTN_IDX_W-1:0] r_code;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic [HOLD_W-1:0] r_hold;

            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .key_n (key_n[gi]),
                .stable(w_stable[gi])
            );

            // A fresh press reloads even if a frame tick lands in the same cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold <= '0;
                end else if (w_rise[gi]) begin
                    r_hold <= HOLD_LOAD;
                end else if (frame_tick && (r_hold != '0)) begin
                    r_hold <= r_hold - HOLD_W'(1);
                end
            end

            assign btn_state[gi] = w_stable[gi] | (r_hold != '0);
        end
    endgenerate

    assign w_rise = w_stable & ~r_stable_d;

    // A press landing on the bit being accepted survives, yielding a second event.
    always_comb begin
        w_clear = '0;
        if (r_valid && evt_ack) begin
            w_clear = NUM_BTN'(1) << r_code;
        end
        w_pend_next = (r_pend & ~w_clear) | w_rise;
    end

    // Selection is registered from the next pend value so it tracks r_pend exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable_d <= '0;
            r_pend     <= '0;
            r_valid    <= 1'b0;
            r_code     <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_pend     <= w_pend_next;
            r_valid    <= |w_pend_next;
            r_code     <= btn_prio_code(w_pend_next);
        end
    end

    assign evt_valid = r_valid;
    assign evt_code  = r_code;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl: expected event codes go into a scoreboard
// queue and a negedge monitor checks every accepted event against it.
module tb_btn_input_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic       frame_tick;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ack;

    int total = 0;
    int bad   = 0;
    int sb[$];

    always #5 clk = ~clk;

    btn_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4),
        .HOLD_FRAMES    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .frame_tick(frame_tick),
        .btn_state (btn_state),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ack   (evt_ack)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        cycles(1);
        frame_tick = 1'b0;
    endtask

    task automatic release_all();
        key_n = 4'hF;
        cycles(8);
        tick_frame();
        tick_frame();
        cycles(2);
    endtask

    // Monitor: an event is handed off at the next edge whenever valid and ack are both high.
    initial begin
        int exp_code;
        forever begin
            @(negedge clk);
            if (!rst && evt_valid && evt_ack) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL evt_extra: got code=%0d required no event", evt_code);
                end else begin
                    exp_code = sb.pop_front();
                    if (int'(evt_code) !== exp_code) begin
                        bad++;
                        $display("FAIL evt_code: got=%0d required=%0d", evt_code, exp_code);
                    end else begin
                        $display("ok   evt_accept: code=%0d", evt_code);
                    end
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        key_n      = 4'hF;
        frame_tick = 1'b0;
        evt_ack    = 1'b0;
        cycles(3);
        check("rst_btn_state", int'(btn_state), 0);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_code", int'(evt_code), 0);
        rst = 1'b0;
        cycles(2);

        // Glitch of 3 cycles on key 2 must be swallowed.
        key_n[2] = 1'b0;
        cycles(3);
        key_n[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check("glitch_btn_state", int'(btn_state), 0);
            check("glitch_evt_valid", int'(evt_valid), 0);
        end

        // Clean press on key 2.
        key_n[2] = 1'b0;
        sb.push_back(2);
        cycles(5);
        check("press_btn_before", int'(btn_state), 0);
        cycles(1);
        check("press_btn_state", int'(btn_state), 4);
        check("press_valid_early", int'(evt_valid), 0);
        cycles(1);
        check("press_evt_valid", int'(evt_valid), 1);
        check("press_evt_code", int'(evt_code), 2);
        cycles(1);
        evt_ack = 1'b1;
        cycles(1);
        evt_ack = 1'b0;
        check("press_after_ack", int'(evt_valid), 0);
        release_all();
        check("press_cleared", int'(btn_state), 0);

        // Highlight stretch on key 0 after release.
        key_n[0] = 1'b0;
        sb.push_back(0);
        cycles(7);
        check("hold_pressed", int'(btn_state), 1);
        evt_ack = 1'b1;
        cycles(1);
        evt_ack = 1'b0;
        key_n[0] = 1'b1;
        cycles(8);
        check("hold_after_release", int'(btn_state), 1);
        cycles(2);
        tick_frame();
        check("hold_after_tick1", int'(btn_state), 1);
        cycles(8);
        check("hold_before_tick2", int'(btn_state), 1);
        tick_frame();
        check("hold_after_tick2", int'(btn_state), 0);
        cycles(2);

        // Arbitration: keys 0, 1, 3 together, drained in priority order.
        key_n = 4'b0100;
        sb.push_back(3);
        sb.push_back(1);
        sb.push_back(0);
        cycles(7);
        check("arb_valid", int'(evt_valid), 1);
        check("arb_first_code", int'(evt_code), 3);
        evt_ack = 1'b1;
        cycles(3);
        check("arb_drained", int'(evt_valid), 0);
        evt_ack = 1'b0;
        release_all();

        // Collision: a new rise on key 1 in the cycle its pending event is accepted.
        key_n[1] = 1'b0;
        sb.push_back(1);
        cycles(7);
        check("coll_first_valid", int'(evt_valid), 1);
        check("coll_first_code", int'(evt_code), 1);
        key_n[1] = 1'b1;
        cycles(8);
        check("coll_still_pending", int'(evt_valid), 1);
        key_n[1] = 1'b0;
        sb.push_back(1);
        cycles(6);
        evt_ack = 1'b1;
        cycles(1);
        evt_ack = 1'b0;
        check("coll_valid_kept", int'(evt_valid), 1);
        check("coll_code_kept", int'(evt_code), 1);
        evt_ack = 1'b1;
        cycles(1);
        evt_ack = 1'b0;
        check("coll_done", int'(evt_valid), 0);
        release_all();

        // Async reset mid-debounce with a pending event on key 3.
        key_n[3] = 1'b0;
        cycles(7);
        check("ar_pre_valid", int'(evt_valid), 1);
        check("ar_pre_btn", int'(btn_state), 8);
        key_n[0] = 1'b0;
        cycles(4);
        #2 rst = 1'b1;
        #1;
        check("ar_btn_state", int'(btn_state), 0);
        check("ar_evt_valid", int'(evt_valid), 0);
        check("ar_evt_code", int'(evt_code), 0);
        cycles(2);
        rst = 1'b0;
        sb.push_back(3);
        sb.push_back(0);
        cycles(5);
        check("ar_btn_before", int'(btn_state), 0);
        cycles(1);
        check("ar_btn_state_back", int'(btn_state), 9);
        cycles(1);
        check("ar_evt_valid_back", int'(evt_valid), 1);
        check("ar_evt_code_back", int'(evt_code), 3);
        evt_ack = 1'b1;
        cycles(2);
        evt_ack = 1'b0;
        check("ar_drained", int'(evt_valid), 0);
        release_all();

        check("final_evt_valid", int'(evt_valid), 0);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_input_ctrl.md
# btn_input_ctrl

Input-side controller for the bottom bar and the game core. It synchronises and debounces the four raw board keys and drives `btn_state[3:0]` for the bottom bar's highlight, stretching each highlight over a minimum number of frames. It also queues one press event per button and arbitrates them onto a single valid/ack channel that the game logic consumes, with one event handed off per handshake. It sits between the board key pins and both the bottom-bar renderer and the game-state logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 1.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `HOLD_FRAMES`, default 6: minimum highlight length, in frames, after an accepted press; 0 disables stretching.

Ports:
- `clk`, in, 1: system/pixel-domain clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `key_n`, in, 4: raw keys, active-low, asynchronous. Bit 0 = right, 1 = left, 2 = up, 3 = aux.
- `frame_tick`, in, 1: one-cycle pulse per frame, at the start of vertical blank.
- `btn_state`, out, 4: highlight level per button, active-high; feeds the bottom bar.
- `evt_valid`, out, 1: a press event is pending.
- `evt_code`, out, 2: index of the button for the presented event.
- `evt_ack`, in, 1: consumer accepts the event this cycle.

## Operation
- **Synchroniser:** two flops per key, inverted to active-high. Both flops reset to 0 (released).
- **Debounce, per bit:** holds the `stable` level and a counter `cnt`.
  - If `sync == stable`: `cnt <= 0`.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1`, `stable <= sync` and `cnt <= 0`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- **Press edge:** `rise[i]` = `stable[i]` is 1 and its previous value was 0. The delayed copy is a register that resets to 0. Releases generate no event.
- **Hold counter, per bit:** `hold[i]` is `ceil(log2(HOLD_FRAMES+1))` bits wide.
  - On `rise[i]`, `hold[i] <= HOLD_FRAMES`.
  - Otherwise, on `frame_tick` with `hold[i] != 0`, `hold[i]` decrements.
  - If reload and `frame_tick` occur in the same cycle, the reload wins.
- **Highlight output:** `btn_state[i] = stable[i] | (hold[i] != 0)`, combinational from registers.
- **Pending events:** register `pend[3:0]`. `rise[i]` sets `pend[i]`; acceptance clears it.
- **Arbiter:** fixed priority 3 > 2 > 1 > 0, computed as a registered selection.
  - `evt_valid = |pend`.
  - `evt_code` is the highest set bit of `pend`.
- **Acceptance:** happens in a cycle where `evt_valid && evt_ack`, and clears `pend[evt_code]`. `evt_ack` is ignored while `evt_valid` is 0.
- **Set/clear collision:** if `rise` on the presented bit coincides with acceptance, `pend` stays set. The new press is preserved, so a second event follows.
- **Repeat presses:** a second press of a bit that is already pending merges into one event. At most one outstanding event per button.
- **Stability while waiting:** while `evt_valid && !evt_ack`, `evt_code` may change only to a higher-priority bit that becomes newly pending.

## Timing
- **Reset values:** all registers 0. Therefore `btn_state = 0`, `evt_valid = 0`, `evt_code = 0`.
- **Press latency:** `key_n` falls and is first sampled at edge E.
  - `stable` rises at edge E+1+DEBOUNCE_CYCLES.
  - `btn_state` rises at that same edge.
  - `rise` is asserted on the following cycle. `pend` and `hold` update at edge E+2+DEBOUNCE_CYCLES, which is also where `evt_valid` rises.
- **Release latency:** same pipeline; `stable` falls at E+1+DEBOUNCE_CYCLES.
- **Highlight length:** `btn_state` stays 1 until `stable` is 0 and `HOLD_FRAMES` `frame_tick`s have occurred after the `hold` load.
- **Back-to-back handshakes:** after acceptance at edge A, the next pending event is presented right after A, so one event can be accepted per cycle.
- **Reset mid-operation:** all state clears immediately. A key held through reset is reported as a new press after the full debounce time.

## Structure
- Shared package `btn_pkg`: button index constants (`BTN_RIGHT`=0, `BTN_LEFT`=1, `BTN_UP`=2, `BTN_AUX`=3) and `NUM_BTN`=4. The bottom-bar renderer and game core reuse these constants.
- Sub-module `btn_debounce`: synchroniser, counter and `stable` for one bit, instantiated four times.
- The top level holds edge detection, hold counters, the pend register and the arbiter.

## Test plan
Unless noted, `DEBOUNCE_CYCLES=4`, `HOLD_FRAMES=2`.
1. **Glitch rejection:** `key_n[2]` low for 3 cycles, then high → `btn_state`, `evt_valid` stay 0.
2. **Clean press:** `key_n[2]` low at edge 0 and held → `btn_state[2]`=1 after edge 5; `evt_valid`=1 with `evt_code`=2 after edge 6. Ack at edge 8 → `evt_valid`=0 after edge 8.
3. **Highlight stretch:** press then release bit 0; `stable` falls at cycle 30; `frame_tick` at 40 and 50 → `btn_state[0]` high until edge 50 and 0 after it.
4. **Arbitration:** bits 0, 1, 3 pending together; `evt_ack` held 1 → codes 3, 1, 0 on consecutive cycles, then `evt_valid`=0.
5. **Collision:** `rise[1]` in the same cycle as acceptance of code 1 → `evt_valid` stays 1 with code 1, and exactly two events total.
6. **Async reset mid-debounce:** `rst` pulse while `key_n[0]` is held low at `cnt`=2 → all outputs 0 immediately. Press reported 5 cycles after `rst` deasserts, i.e. the full debounce time.
